// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and key-code helpers for the keypad matrix emulator
package keypad_pkg;

    localparam int KEY_W = 4;
    localparam logic [3:0] ROW_IDLE = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_B_IN  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_B_OUT = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    // Key code layout: row index in [3:2], column index in [1:0].
    function automatic logic [1:0] key_row(input logic [KEY_W-1:0] key);
        return key[3:2];
    endfunction

    function automatic logic [1:0] key_col(input logic [KEY_W-1:0] key);
        return key[1:0];
    endfunction

endpackage

// File: rtl/keypad_cmd_fifo.sv
// rtl/keypad_cmd_fifo.sv - synchronous command FIFO for queued key presses
//   clk, rst (async, active-low)
//   push, push_data : write side, ignored while full
//   pop, pop_data   : read side, pop_data shows the head, ignored while empty
//   full, empty     : occupancy flags
module keypad_cmd_fifo
    import keypad_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = KEY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    // A pop in the same cycle never frees room for a push while full.
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/keypad_matrix_emulator.sv
// rtl/keypad_matrix_emulator.sv - row side of a 4x4 keypad with bounce, hold and release
//   clk, rst (async, active-low)
//   col         : column drive from scanner, active-low
//   row         : row sense to scanner, active-low, 4'hF with no contact
//   press_valid, press_key, press_ready : press command queue handshake
//   busy        : press in progress or commands queued
//   done        : one-cycle pulse in the last cycle of each press's open gap
module keypad_matrix_emulator
    import keypad_pkg::*;
#(
    parameter int HOLD_CYCLES   = 16,
    parameter int BOUNCE_CYCLES = 4,
    parameter int GAP_CYCLES    = 8,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       col,
    output logic [3:0]       row,
    input  logic             press_valid,
    input  logic [KEY_W-1:0] press_key,
    output logic             press_ready,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] LAST_BOUNCE = CNT_W'(BOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_HOLD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_GAP    = CNT_W'(GAP_CYCLES - 1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             contact;
    logic             contact_nx;
    logic [KEY_W-1:0] cur_key;
    logic [KEY_W-1:0] head_key;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;

    keypad_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (KEY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (press_valid),
        .push_data (press_key),
        .pop       (pop),
        .pop_data  (head_key),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign press_ready = !fifo_full;
    assign busy        = (state != ST_IDLE) || !fifo_empty;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + CNT_W'(1);
        pop      = 1'b0;
        done     = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_nx = '0;
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    state_nx = (BOUNCE_CYCLES == 0) ? ST_HOLD : ST_B_IN;
                end
            end
            ST_B_IN: begin
                if (cnt == LAST_BOUNCE) begin
                    state_nx = ST_HOLD;
                    cnt_nx   = '0;
                end
            end
            ST_HOLD: begin
                if (cnt == LAST_HOLD) begin
                    state_nx = (BOUNCE_CYCLES == 0) ? ST_GAP : ST_B_OUT;
                    cnt_nx   = '0;
                end
            end
            ST_B_OUT: begin
                if (cnt == LAST_BOUNCE) begin
                    state_nx = ST_GAP;
                    cnt_nx   = '0;
                end
            end
            ST_GAP: begin
                if (cnt == LAST_GAP) begin
                    done     = 1'b1;
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Contact is registered from the next state/count so it lines up
    // exactly with the cycle the FSM spends in that state.
    always_comb begin
        contact_nx = 1'b0;
        case (state_nx)
            ST_B_IN:  contact_nx = !cnt_nx[0];
            ST_HOLD:  contact_nx = 1'b1;
            ST_B_OUT: contact_nx = cnt_nx[0];
            default:  contact_nx = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            contact <= 1'b0;
            cur_key <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            contact <= contact_nx;
            if (pop) begin
                cur_key <= head_key;
            end
        end
    end

    // Zero-latency path from col to row; only the pressed key's row can go low.
    always_comb begin
        row = ROW_IDLE;
        if (contact && !col[key_col(cur_key)]) begin
            row[key_row(cur_key)] = 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// tb/tb_keypad_matrix_emulator.sv - self-checking bench for keypad_matrix_emulator
module tb_keypad_matrix_emulator;

    localparam int H = 16;
    localparam int G = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] col;
    logic [3:0] press_key;
    logic       pv     [2];
    logic [3:0] row_o  [2];
    logic       rdy_o  [2];
    logic       busy_o [2];
    logic       done_o [2];

    always #5 clk = ~clk;

    keypad_matrix_emulator #(.HOLD_CYCLES(H), .BOUNCE_CYCLES(0), .GAP_CYCLES(G), .FIFO_DEPTH(4)) dut0 (
        .clk(clk), .rst(rst), .col(col), .row(row_o[0]),
        .press_valid(pv[0]), .press_key(press_key), .press_ready(rdy_o[0]),
        .busy(busy_o[0]), .done(done_o[0])
    );

    keypad_matrix_emulator #(.HOLD_CYCLES(H), .BOUNCE_CYCLES(4), .GAP_CYCLES(G), .FIFO_DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .col(col), .row(row_o[1]),
        .press_valid(pv[1]), .press_key(press_key), .press_ready(rdy_o[1]),
        .busy(busy_o[1]), .done(done_o[1])
    );

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each press is a flat profile of 2*B+H+G cycles.
    int         mb   [2] = '{0, 4};
    int         mqn  [2] = '{0, 0};
    int         mpos [2] = '{-1, -1};
    logic [3:0] mq   [2][4];
    logic [3:0] mcur [2] = '{4'h0, 4'h0};
    bit         macc [2] = '{1'b0, 1'b0};
    int         dcnt [2] = '{0, 0};

    function automatic int plen(input int d);
        return 2 * mb[d] + H + G;
    endfunction

    function automatic bit mcontact(input int d);
        int i;
        int b;
        i = mpos[d];
        b = mb[d];
        if (i < 0)         return 1'b0;
        if (i < b)         return (i % 2) == 0;
        if (i < b + H)     return 1'b1;
        if (i < 2 * b + H) return ((i - b - H) % 2) == 1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] mrow(input int d);
        logic [3:0] r;
        logic [3:0] k;
        r = 4'hF;
        k = mcur[d];
        if (mcontact(d) && col[k[1:0]] == 1'b0) r[k[3:2]] = 1'b0;
        return r;
    endfunction

    function automatic bit model_idle();
        return mpos[0] < 0 && mqn[0] == 0 && mpos[1] < 0 && mqn[1] == 0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                mqn[d]  = 0;
                mpos[d] = -1;
                macc[d] = 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                macc[d] = pv[d] && (mqn[d] < 4);
                if (mpos[d] < 0) begin
                    if (mqn[d] > 0) begin
                        mcur[d] = mq[d][0];
                        for (int j = 0; j < 3; j++) mq[d][j] = mq[d][j+1];
                        mqn[d]--;
                        mpos[d] = 0;
                    end
                end else if (mpos[d] == plen(d) - 1) begin
                    mpos[d] = -1;
                end else begin
                    mpos[d]++;
                end
                if (macc[d]) begin
                    mq[d][mqn[d]] = press_key;
                    mqn[d]++;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("row%0d", d),  row_o[d],  mrow(d));
            chk($sformatf("rdy%0d", d),  rdy_o[d],  mqn[d] < 4);
            chk($sformatf("busy%0d", d), busy_o[d], mpos[d] >= 0 || mqn[d] > 0);
            chk($sformatf("done%0d", d), done_o[d], mpos[d] == plen(d) - 1);
            if (rst === 1'b1 && done_o[d] === 1'b1) dcnt[d]++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] k);
        press_key = k;
        pv[0] = 1'b1;
        pv[1] = 1'b1;
        tick();
        pv[0] = 1'b0;
        pv[1] = 1'b0;
        chk("push_acc0", macc[0], 1);
        chk("push_acc4", macc[1], 1);
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        while (!model_idle() && n < maxc) begin
            tick();
            n++;
        end
        nchk++;
        if (!model_idle()) begin
            nerr++;
            $display("FAIL wait_idle: timeout after %0d cycles", maxc);
        end
        tick();
    endtask

    typedef struct {
        logic [3:0] key;
        logic [3:0] col;
        logic [3:0] exp_row;
    } vec_t;

    vec_t       vt [8];
    logic [3:0] colseq [4];
    logic [3:0] bkeys [6];
    logic [3:0] exp_r;
    int         dc0;
    int         dc1;
    int         cnt_a;
    int         cnt_b;
    int         n;

    initial begin
        vt[0] = '{4'd6,  4'b1011, 4'b1101};
        vt[1] = '{4'd6,  4'b1110, 4'b1111};
        vt[2] = '{4'd15, 4'b0111, 4'b0111};
        vt[3] = '{4'd0,  4'b1110, 4'b1110};
        vt[4] = '{4'd9,  4'b1101, 4'b1011};
        vt[5] = '{4'd9,  4'b0000, 4'b1011};
        vt[6] = '{4'd3,  4'b0110, 4'b1110};
        vt[7] = '{4'd12, 4'b1111, 4'b1111};
        colseq[0] = 4'b1110; colseq[1] = 4'b1101; colseq[2] = 4'b1011; colseq[3] = 4'b0111;
        bkeys[0] = 4'd0; bkeys[1] = 4'd5; bkeys[2] = 4'd10;
        bkeys[3] = 4'd15; bkeys[4] = 4'd4; bkeys[5] = 4'd9;

        rst = 1'b0;
        col = 4'hF;
        press_key = 4'h0;
        pv[0] = 1'b0;
        pv[1] = 1'b0;

        // Reset hold and release with scanning columns
        for (int i = 0; i < 8; i++) begin
            col = colseq[i % 4];
            tick();
            if (i == 4) rst = 1'b1;
            chk("rst_row0", row_o[0], 4'hF);
            chk("rst_row4", row_o[1], 4'hF);
            chk("rst_rdy", rdy_o[0], 1);
            chk("rst_busy", busy_o[1], 0);
            chk("rst_done", done_o[0], 0);
        end

        // Key 6, column 2 driven: solid 16-cycle hold on dut0
        col = 4'b1011;
        dc0 = dcnt[0];
        cnt_a = 0;
        push(4'd6);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (row_o[0] == 4'b1101) cnt_a++;
            tick();
        end
        chk("hold_len", cnt_a, 16);
        chk("done_once", dcnt[0] - dc0, 1);
        wait_idle(100);

        // Key 6 with wrong column: no contact visible, done still pulses
        col = 4'b1110;
        dc0 = dcnt[0];
        dc1 = dcnt[1];
        cnt_b = 0;
        push(4'd6);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (row_o[0] != 4'hF || row_o[1] != 4'hF) cnt_b++;
            tick();
        end
        chk("wrong_col_rows", cnt_b, 0);
        chk("wrong_col_done0", dcnt[0] - dc0, 1);
        chk("wrong_col_done4", dcnt[1] - dc1, 1);
        wait_idle(100);

        // Key 15 bounce profile on dut4
        col = 4'b0111;
        push(4'd15);
        tick();
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (i < 4)       exp_r = (i % 2 == 0) ? 4'b0111 : 4'b1111;
            else if (i < 20) exp_r = 4'b0111;
            else if (i < 24) exp_r = ((i - 20) % 2 == 0) ? 4'b1111 : 4'b0111;
            else             exp_r = 4'b1111;
            chk($sformatf("bounce_prof[%0d]", i), row_o[1], exp_r);
            if (i == 31) chk("bounce_done", done_o[1], 1);
            tick();
        end
        wait_idle(100);

        // Table of key/column pairs sampled mid-hold
        for (int v = 0; v < 8; v++) begin
            col = 4'hF;
            push(vt[v].key);
            repeat (9) tick();
            col = vt[v].col;
            @(negedge clk);
            chk($sformatf("vec%0d_row0", v), row_o[0], vt[v].exp_row);
            chk($sformatf("vec%0d_row4", v), row_o[1], vt[v].exp_row);
            wait_idle(100);
        end

        // Burst of six commands with press_valid held until accepted
        col = 4'b0000;
        dc0 = dcnt[0];
        dc1 = dcnt[1];
        for (int k = 0; k < 6; k++) begin
            press_key = bkeys[k];
            pv[0] = 1'b1;
            pv[1] = 1'b1;
            n = 0;
            while ((pv[0] || pv[1]) && n < 200) begin
                tick();
                if (macc[0]) pv[0] = 1'b0;
                if (macc[1]) pv[1] = 1'b0;
                n++;
            end
            chk($sformatf("burst_acc%0d", k), pv[0] | pv[1], 0);
            if (k == 4) begin
                chk("burst_full0", rdy_o[0], 0);
                chk("burst_full4", rdy_o[1], 0);
            end
            if (k == 5) chk("burst_wait", n > 20, 1);
        end
        pv[0] = 1'b0;
        pv[1] = 1'b0;
        wait_idle(500);
        chk("burst_done0", dcnt[0] - dc0, 6);
        chk("burst_done4", dcnt[1] - dc1, 6);

        // Asynchronous reset mid-hold of key 0
        col = 4'b1110;
        push(4'd0);
        push(4'd5);
        repeat (10) tick();
        chk("pre_rst_row0", row_o[0], 4'b1110);
        dc0 = dcnt[0];
        dc1 = dcnt[1];
        #2;
        rst = 1'b0;
        #1;
        chk("async_row0", row_o[0], 4'hF);
        chk("async_row4", row_o[1], 4'hF);
        chk("async_busy", busy_o[0], 0);
        tick();
        rst = 1'b1;
        repeat (40) tick();
        chk("rst_nodone0", dcnt[0] - dc0, 0);
        chk("rst_nodone4", dcnt[1] - dc1, 0);
        chk("rst_empty0", busy_o[0], 0);
        chk("rst_empty4", busy_o[1], 0);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            col = 4'($urandom);
            pv[0] = ($urandom_range(0, 7) == 0);
            pv[1] = ($urandom_range(0, 7) == 0);
            press_key = 4'($urandom);
            if ($urandom_range(0, 999) == 0) begin
                #2;
                rst = 1'b0;
                #1;
                rst = 1'b1;
            end
            tick();
        end
        pv[0] = 1'b0;
        pv[1] = 1'b0;
        wait_idle(500);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
